// File: rtl/dsp_mac_ctrl.sv
// Controller for a DSP48A1 multiply-accumulate: accepts len operand pairs, steers
// the slice clock enables and OPMODE, and pulses done when P holds the final sum.
module dsp_mac_ctrl #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_in,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam int unsigned TagW = PIPE_LAT - 1;
  localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

  typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [TagW-1:0]  tag_v_q, tag_v_d;
  logic [TagW-1:0]  tag_f_q, tag_f_d;
  logic [TagW-1:0]  tag_l_q, tag_l_d;
  logic             abort_rst_q, abort_rst_d;
  logic             accept, abort_act, last_acc;
  logic [LEN_W-1:0] count_inc;

  always_comb begin
    accept    = in_valid && (state_q == StRun);
    abort_act = abort && (state_q inside {StClr, StRun, StDrain});
    count_inc = count_q + CntOne;
    last_acc  = accept && (count_inc == len_q);

    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    abort_rst_d = 1'b0;

    // Tag pipeline mirrors the DSP datapath: stage TagW-1 lines up with the P update.
    tag_v_d    = tag_v_q;
    tag_f_d    = tag_f_q;
    tag_l_d    = tag_l_q;
    tag_v_d[0] = accept;
    tag_f_d[0] = (count_q == '0);
    tag_l_d[0] = last_acc;
    for (int i = 1; i < TagW; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_f_d[i] = tag_f_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          count_d = '0;
          state_d = (len == '0) ? StClr : StRun;
        end
      end
      StClr: state_d = StDone;
      StRun: begin
        if (accept) count_d = count_inc;
        if (last_acc) state_d = StDrain;
      end
      StDrain: begin
        if (tag_v_q[TagW-1] && tag_l_q[TagW-1]) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over a same-cycle accept: the pair stays counted but never reaches P.
    if (abort_act) begin
      state_d     = StIdle;
      abort_rst_d = 1'b1;
      tag_v_d     = '0;
      tag_f_d     = '0;
      tag_l_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      tag_v_q     <= '0;
      tag_f_q     <= '0;
      tag_l_q     <= '0;
      abort_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      tag_v_q     <= tag_v_d;
      tag_f_q     <= tag_f_d;
      tag_l_q     <= tag_l_d;
      abort_rst_q <= abort_rst_d;
    end
  end

  always_comb begin
    in_ready = (state_q == StRun);
    ce_in    = (state_q == StRun) || (state_q == StDrain);
    ce_m     = ce_in;
    ce_p     = tag_v_q[TagW-1];
    opmode   = !ce_p ? 8'h00 : (tag_f_q[TagW-1] ? 8'h01 : 8'h09);
    rst_p    = (state_q == StClr) || abort_rst_q;
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    count    = count_q;
  end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Directed bench for dsp_mac_ctrl at PIPE_LAT=4 with a small behavioural DSP48A1
// datapath so the accumulated P value can be checked alongside the control timing.
module tb_dsp_mac_ctrl;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned PIPE_LAT = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid;
  logic [LEN_W-1:0] len;
  logic             in_ready, ce_in, ce_m, ce_p, rst_p, busy, done;
  logic [7:0]       opmode;
  logic [LEN_W-1:0] count;

  logic [7:0]  a_in, b_in, a1, b1, a2, b2;
  logic [15:0] m_r;
  logic [31:0] p_r;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen;

  dsp_mac_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .ce_in(ce_in), .ce_m(ce_m),
    .ce_p(ce_p), .rst_p(rst_p), .opmode(opmode), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  // A/B (two stages), M and P registers: pair accepted in t updates P at end of t+3.
  always @(posedge clk) begin
    if (ce_in) begin
      a1 <= a_in; b1 <= b_in; a2 <= a1; b2 <= b1;
    end
    if (ce_m) m_r <= a2 * b2;
    if (rst_p) p_r <= 32'd0;
    else if (ce_p && opmode == 8'h01) p_r <= {16'd0, m_r};
    else if (ce_p && opmode == 8'h09) p_r <= p_r + {16'd0, m_r};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0;
    a_in = 8'd0; b_in = 8'd0;
    #2;
    check("rst_ctl", {25'd0, in_ready, ce_in, ce_m, ce_p, rst_p, busy, done}, 32'd0);
    check("rst_opmode", {24'd0, opmode}, 32'd0);
    check("rst_count", {24'd0, count}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", {30'd0, rst_p, busy}, 32'd0);

    // Burst of three, with a len=7 start during RUN that must be ignored.
    start = 1'b1; len = 8'd3; tick();
    start = 1'b0;
    check("burst_c1_ready", {31'd0, in_ready}, 32'd1);
    check("burst_c1_ce_in", {30'd0, ce_in, ce_m}, 32'd3);
    in_valid = 1'b1; a_in = 8'd2; b_in = 8'd3; tick();
    a_in = 8'd4; b_in = 8'd5; start = 1'b1; len = 8'd7; tick();
    start = 1'b0; len = 8'd0; a_in = 8'd1; b_in = 8'd1;
    check("burst_c3_cep", {31'd0, ce_p}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("burst_c4_ready", {31'd0, in_ready}, 32'd0);
    check("burst_c4_op", {23'd0, ce_p, opmode}, 32'h101);
    tick();
    check("burst_c5_op", {23'd0, ce_p, opmode}, 32'h109);
    tick();
    check("burst_c6_op", {23'd0, ce_p, opmode, done}, 32'h212);
    tick();
    check("burst_c7_done", {30'd0, done, ce_p}, 32'd2);
    check("burst_count", {24'd0, count}, 32'd3);
    check("burst_p", p_r, 32'd27);
    tick();
    check("burst_c8_idle", {30'd0, done, busy}, 32'd0);

    // Bubbles: accepts in cycles 1 and 4 only.
    start = 1'b1; len = 8'd2; tick();
    start = 1'b0; in_valid = 1'b1; a_in = 8'd3; b_in = 8'd7; tick();
    in_valid = 1'b0; a_in = 8'd9; b_in = 8'd9;
    check("bub_c2_count", {24'd0, count}, 32'd1);
    tick(); tick();
    in_valid = 1'b1; a_in = 8'd2; b_in = 8'd2;
    check("bub_c4_op", {23'd0, ce_p, opmode}, 32'h101);
    tick();
    in_valid = 1'b0; a_in = 8'd9; b_in = 8'd9;
    check("bub_c5_hold", {23'd0, ce_p, opmode}, 32'h000);
    tick();
    check("bub_c6_hold", {23'd0, ce_p, opmode, done}, 32'h000);
    tick();
    check("bub_c7_op", {23'd0, ce_p, opmode, done}, 32'h212);
    tick();
    check("bub_c8_done", {31'd0, done}, 32'd1);
    check("bub_p", p_r, 32'd25);
    tick();

    // Empty command.
    start = 1'b1; len = 8'd0; tick();
    start = 1'b0;
    check("empty_c1", {29'd0, rst_p, in_ready, busy}, 32'd5);
    tick();
    check("empty_c2", {29'd0, done, rst_p, in_ready}, 32'd4);
    check("empty_p", p_r, 32'd0);
    tick();
    check("empty_c3_idle", {31'd0, busy}, 32'd0);

    // Abort in cycle 3 of a len=5 command.
    start = 1'b1; len = 8'd5; tick();
    start = 1'b0; in_valid = 1'b1; a_in = 8'd1; b_in = 8'd1; tick(); tick();
    abort = 1'b1; tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_c4", {28'd0, ce_p, rst_p, busy, in_ready}, 32'd4);
    check("abort_count", {24'd0, count}, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || ce_p || busy) seen = 1'b1;
    end
    check("abort_quiet", {31'd0, seen}, 32'd0);
    check("abort_p", p_r, 32'd0);

    // Reset asserted in the cycle after the last accept (DRAIN).
    start = 1'b1; len = 8'd1; tick();
    start = 1'b0; in_valid = 1'b1; a_in = 8'd5; b_in = 8'd5; tick();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_ctl", {24'd0, ce_in, ce_m, ce_p, rst_p, busy, done, in_ready, 1'b0}, 32'd0);
    check("mid_rst_out", {16'd0, opmode, count}, 32'd0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_quiet", {31'd0, seen}, 32'd0);
    start = 1'b1; len = 8'd1; tick();
    start = 1'b0; in_valid = 1'b1; tick();
    in_valid = 1'b0; n = 2;
    while (!done && n < 20) begin tick(); n++; end
    check("post_rst_done_cycle", n, 32'd5);
    tick();

    // Maximum length completes without wrapping the counter.
    start = 1'b1; len = 8'd255; tick();
    start = 1'b0; in_valid = 1'b1; n = 1;
    while (!done && n < 400) begin tick(); n++; end
    in_valid = 1'b0;
    check("max_done_cycle", n, 32'd259);
    check("max_count", {24'd0, count}, 32'd255);
    tick();
    check("max_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_ctrl.md
DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, giving the width of the command length and the pair counter.
REQ-002 The block SHALL have parameter PIPE_LAT, default 4, giving the DSP48A1 cycles from operand accept to P output valid, legal range 2..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-005 The block SHALL have port start, input, 1 bit: command strobe, sampled only in IDLE.
REQ-006 The block SHALL have port len, input, LEN_W bits: number of operand pairs to accumulate, latched on accepted start.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels the current command.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the operand pair at the DSP A/B inputs is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the controller accepts the pair this cycle.
REQ-010 The block SHALL have port ce_in, output, 1 bit: DSP A/B/D register clock enable.
REQ-011 The block SHALL have port ce_m, output, 1 bit: DSP M register clock enable.
REQ-012 The block SHALL have port ce_p, output, 1 bit: DSP P register clock enable.
REQ-013 The block SHALL have port rst_p, output, 1 bit: DSP P register synchronous reset.
REQ-014 The block SHALL have port opmode, output, 8 bits: DSP48A1 OPMODE.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when P holds the final sum.
REQ-017 The block SHALL have port count, output, LEN_W bits: pairs accepted in the current or last command.

Function
REQ-018 States SHALL be IDLE, CLR, RUN, DRAIN and DONE; cycle n is the cycle after the edge that sampled start.
REQ-019 IDLE with start=1 and len!=0 SHALL latch len, clear count and enter RUN; with len=0 it SHALL enter CLR; start outside IDLE SHALL be ignored.
REQ-020 CLR SHALL assert rst_p=1 for one cycle, then enter DONE (P=0 for empty command).
REQ-021 RUN SHALL drive in_ready=1; accept = in_valid&in_ready; each accept increments count.
REQ-022 The accept that makes count equal the latched len SHALL move the block to DRAIN; in_ready SHALL be 0 in all states other than RUN.
REQ-023 ce_in and ce_m SHALL equal 1 in RUN and DRAIN and 0 elsewhere.
REQ-024 For a pair accepted in cycle t, ce_p SHALL be 1 in cycle t+PIPE_LAT-1, with opmode=8'h01 (P=M) if it is the command's first pair, else 8'h09 (P=P+M).
REQ-025 In cycles carrying no accepted pair (bubbles), ce_p SHALL be 0 and opmode SHALL be 8'h00, so P holds.
REQ-026 DRAIN SHALL last until the last pair's ce_p cycle has passed; DONE SHALL then assert done=1 for exactly the cycle t_last+PIPE_LAT, then enter IDLE.
REQ-027 abort=1 in CLR, RUN or DRAIN SHALL clear all in-flight tags, force ce_p=0 from the next cycle, assert rst_p=1 for one cycle and enter IDLE with no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-028 abort and an accept in the same cycle SHALL give abort priority; the accepted pair is discarded but still counted.
REQ-029 count SHALL hold its value after DONE or abort until the next accepted start; len=2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-030 While rst=0, all outputs SHALL be 0 (opmode=8'h00, count=0), state IDLE, tag pipeline cleared, asynchronously and independent of clk.
REQ-031 Reset mid-command SHALL discard the command; after release the block SHALL stay in IDLE until a new start.

Verification (PIPE_LAT=4)
REQ-032 Burst: start, len=3, in_valid=1 from cycle 1 -> accepts in cycles 1-3; ce_p in cycles 4-6 with opmode 01,09,09; done in cycle 7; count=3; A*B pairs (2,3),(4,5),(1,1) give P=27.
REQ-033 Bubbles: len=2, in_valid only in cycles 1 and 4 -> ce_p/opmode 01 in cycle 4 and 09 in cycle 7, ce_p=0 in cycles 5-6, done in cycle 8.
REQ-034 Empty command: len=0 -> rst_p=1 in cycle 1, done in cycle 2, P=0, in_ready never 1.
REQ-035 Abort: len=5, abort in cycle 3 -> no ce_p from cycle 4, rst_p=1 in cycle 4, IDLE in cycle 4 with busy=0, no done pulse, count=3 if in_valid=1 in cycles 1-3.
REQ-036 Reset mid-DRAIN: rst=0 for one cycle in the cycle after the last accept -> all outputs 0 immediately, no done; a following len=1 command gives done exactly PIPE_LAT cycles after its accept.
REQ-037 Start during RUN with len=7 -> ignored; the latched len and done timing are unchanged.
